five_stage_pipeline_core: RTL and testbench
===========================================

# five_stage_pipeline_core

Five-stage in-order RV32I-subset pipeline (IF, ID, EX, MEM, WB) with an integrated word-addressed data RAM. It fetches from an external combinational instruction memory and executes loads and stores against its internal RAM. It resolves data hazards by forwarding or stalling, and control hazards by flushing. The data-RAM write port is exported for bench checking.

## Interface
- NUM_BLOCKS, 128: data RAM depth in 32-bit words (power of two).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  fetch address, equal to the PC.
- imem_rdata  in  32  instruction at imem_addr, combinational, same cycle.
- dmem_we  out  1  RAM write strobe, the MEM-stage store.
- dmem_addr  out  32  MEM-stage byte address.
- dmem_wdata  out  32  MEM-stage store data.
- dmem_rdata  out  32  RAM read data at dmem_addr.

## Operation
- Supported instructions:
  - R-type: ADD, SUB, AND, OR, XOR, SLT, SLL, SRL.
  - I-type: ADDI, ANDI, ORI, XORI, SLTI.
  - Others: LUI, LW, SW, BEQ, BNE, JAL.
- Any other encoding executes as a NOP: no register write, no store, no redirect.
- Register file: 32x32; x0 reads 0 and writes to it are dropped. Two read ports are read in ID; one write port is written in WB. A WB write to the register being read in ID returns the new value in the same cycle.
- ALU: 32-bit wraparound arithmetic. SLT/SLTI compare signed. Shift amount is rs2[4:0] or imm[4:0].
- Immediates are sign-extended. LUI produces imm<<12.
- Branches compare in EX. Targets are PC+imm, using the branch instruction's own PC.
- JAL writes PC+4 to rd; it is resolved in EX like a taken branch.
- A taken branch or jump loads the target PC and flushes IF/ID and ID/EX to bubbles, costing two cycles.
- Data RAM:
  - Index is dmem_addr[log2(NUM_BLOCKS)+1:2]. Higher bits are ignored, so addresses wrap. Bits [1:0] are ignored.
  - Read is combinational. Write is on the clock edge when dmem_we is high.
- Load-use hazard: when the EX-stage instruction is LW and its rd (non-zero) matches a source register of the ID-stage instruction, the hazard unit:
  - holds the PC and IF/ID;
  - inserts one bubble into ID/EX.
- A bubble is a NOP with all write enables low.

## Timing
- In reset:
  - PC=0, so imem_addr=0.
  - All pipeline registers hold bubbles; dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - All registers and all RAM words are cleared to 0.
- The first cycle with rst low fetches address 0.
- Instruction N after reset timing, with no stalls or flushes:
  - in MEM during cycle N+3, where cycle 0 is the first cycle after reset;
  - its register write is visible from cycle N+5.
- Forwarding priority: EX/MEM over MEM/WB over register file. Sources with rs=x0 are never forwarded.
- A stall and a flush in the same cycle: the flush wins and the stall is dropped.
- Asserting rst mid-execution discards all in-flight instructions at the next edge. No partial store occurs in that cycle.

## Configuration
- FORWARDING_EN defined:
  - EX/MEM and MEM/WB results forward to both ALU operands and to SW store data.
  - Only load-use stalls, one cycle each.
- FORWARDING_EN undefined:
  - No forwarding paths.
  - The ID stage stalls while any source register (non-zero) matches the rd of a write-enabled instruction in EX or MEM. The WB case is covered by write-through.
  - Results stay architecturally identical; only cycle counts change.

## Test plan
- Forwarding: ADDI x1,x0,5; ADDI x2,x1,3; ADD x3,x1,x2; SW x3,0(x0) -> dmem_we=1, dmem_addr=0, dmem_wdata=13 in cycle 6 with FORWARDING_EN. Without it, the same values appear later.
- Load-use: after mem[0]=13, LW x4,0(x0); ADD x5,x4,x4; SW x5,4(x0) -> exactly one bubble; mem[1]=26.
- Branch flush: ADDI x1,x0,1; BEQ x1,x1,+12; ADDI x2,x0,7; ADDI x2,x0,9; SW x2,8(x0) -> both flushed ADDIs are squashed; mem[2]=0.
- x0 and JAL: ADDI x0,x0,9; JAL x6,+8 at PC 4; SW x0/x6 -> stored values 0 and 8.
- Address wrap: SW to byte address 4*NUM_BLOCKS (512), then LW from 0 -> reads the stored value.
- Mid-run reset: assert rst for one cycle during a store sequence -> dmem_we stays 0, PC=0, RAM cleared, and execution restarts at address 0.

Source files
------------

// File: rtl/five_stage_pipeline_core_if.sv
// Fetch and data-memory bus of five_stage_pipeline_core.
// master = core side; slave = instruction memory / observer side.
interface five_stage_pipeline_core_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  modport master (output imem_addr, input imem_rdata,
                  output dmem_we, output dmem_addr, output dmem_wdata, output dmem_rdata);
  modport slave  (input imem_addr, output imem_rdata,
                  input dmem_we, input dmem_addr, input dmem_wdata, input dmem_rdata);
endinterface

// File: rtl/five_stage_pipeline_core.sv
// Five-stage in-order RV32I-subset core (IF ID EX MEM WB) with internal word RAM.
// FORWARDING_EN: define to enable EX/MEM and MEM/WB bypass; otherwise ID stalls on RAW.
module five_stage_pipeline_core #(
  parameter int NUM_BLOCKS = 128
) (
  input  logic clk,
  input  logic rst,
  five_stage_pipeline_core_if.master bus
);
  localparam int AW = $clog2(NUM_BLOCKS);

  typedef enum logic [3:0] {A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_SLT, A_SLL, A_SRL, A_PASSB} alu_op_e;

  typedef struct packed {
    alu_op_e     op;
    logic        use_imm, we, ld, st, br, bne, jal;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, imm, a, b;
  } idex_t;

  typedef struct packed {
    logic        we, ld, st;
    logic [4:0]  rd;
    logic [31:0] res, sdata;
  } exmem_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] val;
  } memwb_t;

  logic [31:0] pc, ifid_pc, ifid_ins;
  idex_t       idex, dec;
  exmem_t      exmem;
  memwb_t      memwb;
  logic [31:0] rf  [32];
  logic [31:0] ram [NUM_BLOCKS];

  logic        use1, use2, stall, taken;
  logic [31:0] fa, fb, opb, alu, ex_res, target, daddr;

  // Reset gates the bus so an in-flight store cannot land during the reset cycle.
  assign bus.imem_addr  = rst ? 32'd0 : pc;
  assign daddr          = rst ? 32'd0 : exmem.res;
  assign bus.dmem_addr  = daddr;
  assign bus.dmem_we    = exmem.st & ~rst;
  assign bus.dmem_wdata = rst ? 32'd0 : exmem.sdata;
  assign bus.dmem_rdata = ram[daddr[AW+1:2]];

  // ---------------- ID: decode, register read with WB write-through
  always_comb begin
    dec     = '0;
    use1    = 1'b0;
    use2    = 1'b0;
    dec.rs1 = ifid_ins[19:15];
    dec.rs2 = ifid_ins[24:20];
    dec.rd  = ifid_ins[11:7];
    dec.pc  = ifid_pc;
    case (ifid_ins[6:0])
      7'b0110011: begin
        use1 = 1'b1; use2 = 1'b1; dec.we = 1'b1;
        case ({ifid_ins[31:25], ifid_ins[14:12]})
          {7'h00, 3'd0}: dec.op = A_ADD;
          {7'h20, 3'd0}: dec.op = A_SUB;
          {7'h00, 3'd1}: dec.op = A_SLL;
          {7'h00, 3'd2}: dec.op = A_SLT;
          {7'h00, 3'd4}: dec.op = A_XOR;
          {7'h00, 3'd5}: dec.op = A_SRL;
          {7'h00, 3'd6}: dec.op = A_OR;
          {7'h00, 3'd7}: dec.op = A_AND;
          default: begin dec.we = 1'b0; use1 = 1'b0; use2 = 1'b0; end
        endcase
      end
      7'b0010011: begin
        use1 = 1'b1; dec.we = 1'b1; dec.use_imm = 1'b1;
        dec.imm = {{20{ifid_ins[31]}}, ifid_ins[31:20]};
        case (ifid_ins[14:12])
          3'd0: dec.op = A_ADD;
          3'd2: dec.op = A_SLT;
          3'd4: dec.op = A_XOR;
          3'd6: dec.op = A_OR;
          3'd7: dec.op = A_AND;
          default: begin dec.we = 1'b0; use1 = 1'b0; end
        endcase
      end
      7'b0110111: begin
        dec.we = 1'b1; dec.use_imm = 1'b1; dec.op = A_PASSB;
        dec.imm = {ifid_ins[31:12], 12'd0};
      end
      7'b0000011: if (ifid_ins[14:12] == 3'd2) begin
        use1 = 1'b1; dec.we = 1'b1; dec.ld = 1'b1; dec.use_imm = 1'b1;
        dec.imm = {{20{ifid_ins[31]}}, ifid_ins[31:20]};
      end
      7'b0100011: if (ifid_ins[14:12] == 3'd2) begin
        use1 = 1'b1; use2 = 1'b1; dec.st = 1'b1; dec.use_imm = 1'b1;
        dec.imm = {{20{ifid_ins[31]}}, ifid_ins[31:25], ifid_ins[11:7]};
      end
      7'b1100011: if (ifid_ins[14:13] == 2'd0) begin
        use1 = 1'b1; use2 = 1'b1; dec.br = 1'b1; dec.bne = ifid_ins[12];
        dec.imm = {{19{ifid_ins[31]}}, ifid_ins[31], ifid_ins[7], ifid_ins[30:25], ifid_ins[11:8], 1'b0};
      end
      7'b1101111: begin
        dec.jal = 1'b1; dec.we = 1'b1;
        dec.imm = {{11{ifid_ins[31]}}, ifid_ins[31], ifid_ins[19:12], ifid_ins[20], ifid_ins[30:21], 1'b0};
      end
      default: ;
    endcase
    // Dropping x0 writes here keeps every hazard/bypass compare free of rd!=0 checks.
    if (dec.rd == 5'd0) dec.we = 1'b0;
    dec.a = (memwb.we && memwb.rd == dec.rs1) ? memwb.val : rf[dec.rs1];
    dec.b = (memwb.we && memwb.rd == dec.rs2) ? memwb.val : rf[dec.rs2];
  end

`ifdef FORWARDING_EN
  assign stall = idex.ld && idex.we &&
                 ((use1 && dec.rs1 == idex.rd) || (use2 && dec.rs2 == idex.rd));

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] v,
                                      input exmem_t em, input memwb_t mw);
    if (rs != 5'd0 && em.we && em.rd == rs) return em.res;
    if (rs != 5'd0 && mw.we && mw.rd == rs) return mw.val;
    return v;
  endfunction

  assign fa = fwd(idex.rs1, idex.a, exmem, memwb);
  assign fb = fwd(idex.rs2, idex.b, exmem, memwb);
`else
  assign stall = (idex.we  && ((use1 && dec.rs1 == idex.rd)  || (use2 && dec.rs2 == idex.rd))) ||
                 (exmem.we && ((use1 && dec.rs1 == exmem.rd) || (use2 && dec.rs2 == exmem.rd)));
  assign fa = idex.a;
  assign fb = idex.b;
`endif

  // ---------------- EX
  always_comb begin
    opb = idex.use_imm ? idex.imm : fb;
    case (idex.op)
      A_ADD:   alu = fa + opb;
      A_SUB:   alu = fa - opb;
      A_AND:   alu = fa & opb;
      A_OR:    alu = fa | opb;
      A_XOR:   alu = fa ^ opb;
      A_SLT:   alu = {31'd0, $signed(fa) < $signed(opb)};
      A_SLL:   alu = fa << opb[4:0];
      A_SRL:   alu = fa >> opb[4:0];
      A_PASSB: alu = opb;
      default: alu = 32'd0;
    endcase
    ex_res = idex.jal ? idex.pc + 32'd4 : alu;
    taken  = idex.jal | (idex.br & ((fa == fb) ^ idex.bne));
    target = idex.pc + idex.imm;
  end

  // ---------------- state
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      ifid_pc  <= '0;
      ifid_ins <= '0;
      idex     <= '0;
      exmem    <= '0;
      memwb    <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) ram[i] <= '0;
    end else begin
      if (exmem.st) ram[daddr[AW+1:2]] <= exmem.sdata;
      if (memwb.we) rf[memwb.rd] <= memwb.val;
      memwb.we    <= exmem.we;
      memwb.rd    <= exmem.rd;
      memwb.val   <= exmem.ld ? bus.dmem_rdata : exmem.res;
      exmem.we    <= idex.we;
      exmem.ld    <= idex.ld;
      exmem.st    <= idex.st;
      exmem.rd    <= idex.rd;
      exmem.res   <= ex_res;
      exmem.sdata <= fb;
      // Flush outranks the stall: the stalled ID instruction is on the wrong path anyway.
      if (taken) begin
        pc       <= target;
        ifid_ins <= '0;
        idex     <= '0;
      end else if (stall) begin
        idex     <= '0;
      end else begin
        pc       <= pc + 32'd4;
        ifid_pc  <= pc;
        ifid_ins <= bus.imem_rdata;
        idex     <= dec;
      end
    end
  end
endmodule

// File: tb/tb_five_stage_pipeline_core.sv
// Scoreboard bench: an ISA-level interpreter predicts every store; a monitor
// pops and compares each dmem_we cycle. Directed plus random programs.
module tb_five_stage_pipeline_core;
  localparam int NB = 128;

  logic clk, rst;
  five_stage_pipeline_core_if bus ();
  five_stage_pipeline_core #(.NUM_BLOCKS(NB)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] prog [256];
  logic [63:0] exp_q [$];
  int          st_cyc [$];
  int          cyc;
  int          n_vec = 0, n_err = 0;
  logic [63:0] mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.imem_rdata = (bus.imem_addr < 32'd1024) ? prog[bus.imem_addr[9:2]] : 32'd0;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every store the DUT presents must match the next predicted store.
  always @(negedge clk) begin
    if (rst) begin
      chk("we_in_reset", {31'd0, bus.dmem_we}, 32'd0);
    end else if (bus.dmem_we) begin
      st_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_store", bus.dmem_addr, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("st_addr", bus.dmem_addr, mon_e[63:32]);
        chk("st_data", bus.dmem_wdata, mon_e[31:0]);
      end
    end
  end

  // ---------------- encoders
  function automatic logic [31:0] e_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] e_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] e_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] e_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] e_u(int imm, int rd);
    return {imm[19:0], rd[4:0], 7'h37};
  endfunction

  // ---------------- reference model: sequential ISA interpreter from a clean reset
  task automatic model(input int len);
    logic [31:0] x [32];
    logic [31:0] m [NB];
    logic [31:0] pc, ins, a, b, v, nxt, ii, si, bi, ji, ea;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        wr;
    int          steps;
    foreach (x[i]) x[i] = 32'd0;
    foreach (m[i]) m[i] = 32'd0;
    pc = 32'd0; steps = 0;
    while (pc < 4 * len && steps < 2000) begin
      ins = prog[pc[9:2]];
      rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
      a = x[ins[19:15]]; b = x[ins[24:20]];
      ii = {{20{ins[31]}}, ins[31:20]};
      si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ji = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      nxt = pc + 4; wr = 1'b0; v = 32'd0;
      case (ins[6:0])
        7'h33: begin
          wr = 1'b1;
          if (f7 == 7'h20 && f3 == 3'd0) v = a - b;
          else if (f7 != 7'h00) wr = 1'b0;
          else case (f3)
            3'd0: v = a + b;
            3'd1: v = a << b[4:0];
            3'd2: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: v = a ^ b;
            3'd5: v = a >> b[4:0];
            3'd6: v = a | b;
            3'd7: v = a & b;
            default: wr = 1'b0;
          endcase
        end
        7'h13: begin
          wr = 1'b1;
          case (f3)
            3'd0: v = a + ii;
            3'd2: v = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
            3'd4: v = a ^ ii;
            3'd6: v = a | ii;
            3'd7: v = a & ii;
            default: wr = 1'b0;
          endcase
        end
        7'h37: begin wr = 1'b1; v = {ins[31:12], 12'd0}; end
        7'h03: if (f3 == 3'd2) begin ea = a + ii; wr = 1'b1; v = m[(ea >> 2) % NB]; end
        7'h23: if (f3 == 3'd2) begin
          ea = a + si; m[(ea >> 2) % NB] = b; exp_q.push_back({ea, b});
        end
        7'h63: if ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b)) nxt = pc + bi;
        7'h6f: begin wr = 1'b1; v = pc + 4; nxt = pc + ji; end
        default: ;
      endcase
      if (wr && rd != 5'd0) x[rd] = v;
      pc = nxt;
      steps++;
    end
  endtask

  // ---------------- sequencing
  task automatic clear_prog();
    foreach (prog[i]) prog[i] = 32'd0;
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    exp_q.delete();
    st_cyc.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_imem_addr", bus.imem_addr, 32'd0);
    chk("rst_dmem_addr", bus.dmem_addr, 32'd0);
    chk("rst_dmem_wdata", bus.dmem_wdata, 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("pc_cycle0", bus.imem_addr, 32'd0);
    @(negedge clk);
    chk("pc_cycle1", bus.imem_addr, 32'd4);
  endtask

  task automatic run_prog(input string name, input int len);
    int nexp;
    assert_reset();
    model(len);
    nexp = exp_q.size();
    release_reset();
    repeat (4 * len + 40) @(negedge clk);
    chk({name, "_drain"}, exp_q.size(), 32'd0);
    chk({name, "_nstores"}, st_cyc.size(), nexp);
  endtask

  function automatic logic [31:0] rand_ins();
    int rd  = $urandom_range(0, 7);
    int r1  = $urandom_range(0, 7);
    int r2  = $urandom_range(0, 7);
    int imm = $urandom_range(0, 4095);
    int f3s [5] = '{0, 2, 4, 6, 7};
    int rf3 [6] = '{1, 2, 4, 5, 6, 7};
    case ($urandom_range(0, 15))
      0:       return e_r($urandom_range(0, 1) * 32, r2, r1, 0, rd);
      1, 2:    return e_r(0, r2, r1, rf3[$urandom_range(0, 5)], rd);
      3, 4:    return e_i(imm, r1, f3s[$urandom_range(0, 4)], rd, 'h13);
      5:       return e_u($urandom_range(0, 1048575), rd);
      6, 7:    return e_i(imm, r1, 2, rd, 'h03);
      8, 9:    return e_s(imm, r2, r1, 2);
      10:      return e_b(4 * $urandom_range(1, 4), r2, r1, $urandom_range(0, 1));
      11:      return e_j(4 * $urandom_range(1, 4), rd);
      12: case ($urandom_range(0, 6))
            0:       return e_r(0, r2, r1, 3, rd);
            1:       return e_r(32, r2, r1, 5, rd);
            2:       return e_i(imm, r1, 1, rd, 'h13);
            3:       return e_i(imm, r1, 5, rd, 'h13);
            4:       return e_s(imm, r2, r1, 0);
            5:       return e_b(8, r2, r1, 4);
            default: return 32'd0;
          endcase
      default: return e_i($urandom_range(0, 40), 0, 0, rd, 'h13);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    clear_prog();

    // forwarding chain then load-use
    prog[0] = e_i(5, 0, 0, 1, 'h13);
    prog[1] = e_i(3, 1, 0, 2, 'h13);
    prog[2] = e_r(0, 2, 1, 0, 3);
    prog[3] = e_s(0, 3, 0, 2);
    prog[4] = e_i(0, 0, 2, 4, 'h03);
    prog[5] = e_r(0, 4, 4, 0, 5);
    prog[6] = e_s(4, 5, 0, 2);
    run_prog("fwd_lu", 7);
`ifdef FORWARDING_EN
    chk("fwd_store_cycle", st_cyc.size() > 0 ? st_cyc[0] : -1, 32'd6);
    chk("lu_store_cycle", st_cyc.size() > 1 ? st_cyc[1] : -1, 32'd10);
`else
    chk("nofwd_store_cycle", st_cyc.size() > 0 ? st_cyc[0] : -1, 32'd12);
`endif

    // branch flush
    clear_prog();
    prog[0] = e_i(1, 0, 0, 1, 'h13);
    prog[1] = e_b(12, 1, 1, 0);
    prog[2] = e_i(7, 0, 0, 2, 'h13);
    prog[3] = e_i(9, 0, 0, 2, 'h13);
    prog[4] = e_s(8, 2, 0, 2);
    run_prog("flush", 5);

    // x0 write dropped, JAL link
    clear_prog();
    prog[0] = e_i(9, 0, 0, 0, 'h13);
    prog[1] = e_j(8, 6);
    prog[2] = e_i(5, 0, 0, 7, 'h13);
    prog[3] = e_s(16, 0, 0, 2);
    prog[4] = e_s(20, 6, 0, 2);
    run_prog("jal_x0", 5);

    // address wrap
    clear_prog();
    prog[0] = e_i(55, 0, 0, 1, 'h13);
    prog[1] = e_s(512, 1, 0, 2);
    prog[2] = e_i(0, 0, 2, 2, 'h03);
    prog[3] = e_s(4, 2, 0, 2);
    run_prog("wrap", 4);

    // mid-run reset: the first load sees 0 only if RAM was cleared
    clear_prog();
    prog[0] = e_i(0, 0, 2, 2, 'h03);
    prog[1] = e_i(77, 0, 0, 1, 'h13);
    prog[2] = e_s(12, 2, 0, 2);
    prog[3] = e_s(0, 1, 0, 2);
    prog[4] = e_s(4, 1, 0, 2);
    prog[5] = e_s(8, 1, 0, 2);
    prog[6] = e_s(16, 1, 0, 2);
    assert_reset();
    model(7);
    release_reset();
    for (int k = 0; k < 60 && st_cyc.size() < 3; k++) @(negedge clk);
    chk("midrun_wait", {31'd0, st_cyc.size() >= 3}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    st_cyc.delete();
    @(negedge clk);
    chk("midrun_pc", bus.imem_addr, 32'd0);
    model(7);
    release_reset();
    repeat (60) @(negedge clk);
    chk("midrun_drain", exp_q.size(), 32'd0);
    chk("midrun_nstores", st_cyc.size(), 32'd5);

    // random programs
    for (int t = 0; t < 15; t++) begin
      int len;
      clear_prog();
      len = $urandom_range(20, 40);
      for (int i = 0; i < len; i++) prog[i] = rand_ins();
      run_prog("rand", len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
